regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the write port of the 16-bit general-purpose register bank among several producers: ALU writeback, memory load return, immediate load unit, and debug/test.
- Round-robin arbitration with a valid/ready handshake per requester, plus an optional burst lock.
- Drives one reg_write enable per Register instance and a common 16-bit reg_input bus, both registered one cycle after the handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, data width, matching the Register width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of Register instances driven; must equal 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_lock  input  NUM_REQ  requester i asks to keep the grant after its current beat.
- stall  input  1  freezes arbitration; no handshake completes while high.
- req_ready  output  NUM_REQ  grant, combinational, at most one bit set.
- reg_write  output  NUM_REGS  registered one-hot write enable, bit k drives the reg_write of Register k.
- reg_input  output  DATA_W  registered write data, common to all Registers.
- locked  output  1  high while the arbiter is in LOCKED state.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high, named reset.
- Reset (sampled on a CLK rising edge):
  - reg_write=0, reg_input=0, locked=0.
  - Round-robin pointer rr_ptr=0; state=UNLOCKED.
  - req_ready is forced to 0 while reset=1.
  - Reset mid-operation discards any in-flight pipeline write.
- Handshake:
  - A beat transfers on an edge where req_valid[i]=1 and req_ready[i]=1.
  - Requesters hold req_addr and req_data stable while req_valid=1 and not yet granted.
  - req_valid may drop without a grant; nothing is written.
- Grant rules in UNLOCKED:
  - The winner is the first i with req_valid[i]=1, searching i=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 only if stall=0; otherwise req_ready=0.
  - On a transfer from winner w: rr_ptr <= (w+1) mod NUM_REQ.
  - If req_lock[w]=1 at the transfer: state <= LOCKED, lock_owner <= w, and rr_ptr is not advanced.
- Grant rules in LOCKED:
  - req_ready[lock_owner] = req_valid[lock_owner] & ~stall; all other ready bits are 0.
  - Transfer with req_lock[owner]=0: state <= UNLOCKED, rr_ptr <= (owner+1) mod NUM_REQ.
  - Owner drops req_valid (no transfer) while req_lock=0: return to UNLOCKED, rr_ptr unchanged.
  - Owner drops req_valid while req_lock=1: stay LOCKED.
  - locked = (state==LOCKED).
- Write pipeline, one register stage:
  - On a transfer: reg_write <= one-hot(req_addr[w]) and reg_input <= req_data[w].
  - With no transfer: reg_write <= 0 and reg_input holds its last value.
  - The Register captures on the following edge. Data is visible at the Register output 2 edges after the handshake edge.
- Stall:
  - Blocks new transfers only.
  - A write already in the pipeline stage still issues.
  - rr_ptr and state are frozen.
- Back-to-back:
  - One transfer per cycle, so full throughput.
  - Consecutive writes to the same address are issued in grant order; the later one wins.
- Invariant: reg_write is zero or one-hot; req_ready is zero or one-hot.

Optional Feature:
- Macro: ZERO_REG_PROTECT_EN.
- When defined: a transfer with req_addr=0 completes the handshake normally and updates rr_ptr and lock state, but reg_write stays all-zero for that beat, so Register 0 reads as a constant 0.
- When undefined: address 0 is written like any other register.

Test Plan:
- Reset: hold reset=1 for 2 edges with req_valid=4'b1111 -> req_ready=0, reg_write=0, reg_input=16'h0000, locked=0; after release, first grant goes to requester 0.
- Round-robin: requesters 0..3 all valid continuously, addresses 1,2,3,4, data 16'h1111..16'h4444 -> grants in order 0,1,2,3,0; reg_write sequence 8'h02,8'h04,8'h08,8'h10, each one cycle after its grant; Register 3 outputs 16'h3333 two edges after requester 2's handshake.
- Lock: requester 2 holds req_lock=1 for 3 beats while requesters 0, 1, 3 stay valid -> 3 consecutive grants to 2 with locked=1; the next grant goes to 3.
- Stall: requester 1 granted with data 16'h8888 to addr 5, stall=1 on the next cycle -> reg_write=8'h20, reg_input=16'h8888 still issue; no new req_ready while stall=1; rr_ptr unchanged.
- Reset mid-operation: reset=1 on the edge after a handshake to addr 6 -> reg_write stays 0, so Register 6 keeps its old value; locked=0.
- ZERO_REG_PROTECT_EN:
  - Defined: requester 0 writes 16'hFFFF to addr 0 -> handshake completes, reg_write=0, Register 0 reads 16'h0000.
  - Undefined: same stimulus gives reg_write=8'h01.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the 16-bit register bank, with burst lock.
// Optional ZERO_REG_PROTECT_EN: address-0 beats complete but never write Register 0.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       reg_write,
  output logic [DATA_W-1:0]         reg_input,
  output logic                      locked
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_UNLOCKED,
    S_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       w_rr_nxt;
  logic [PW-1:0]       r_owner;
  logic [PW-1:0]       w_owner_nxt;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_gnt;
  logic                w_found;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [NUM_REGS-1:0] w_wr_nxt;
  logic [NUM_REGS-1:0] r_wr;
  logic [DATA_W-1:0]   r_data;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_gnt     = (r_state == S_LOCKED) ? r_owner : w_win;
    if (!reset && !stall) begin
      unique case (1'b1)
        (r_state == S_LOCKED): req_ready[r_owner] = req_valid[r_owner];
        default:               req_ready[w_win]   = w_found;
      endcase
    end
  end

  assign w_xfer = |req_ready;
  assign w_addr = req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
  assign w_data = req_data[int'(w_gnt)*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    if (!stall) begin
      unique case (1'b1)
        (r_state == S_LOCKED): begin
          // Releasing the lock without a beat leaves the pointer alone.
          if (!req_lock[r_owner]) begin
            w_state_nxt = S_UNLOCKED;
            if (w_xfer) w_rr_nxt = inc_ptr(r_owner);
          end
        end
        default: begin
          if (w_xfer) begin
            if (req_lock[w_gnt]) begin
              w_state_nxt = S_LOCKED;
              w_owner_nxt = w_gnt;
            end else begin
              w_rr_nxt = inc_ptr(w_gnt);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_wr_nxt = '0;
`ifdef ZERO_REG_PROTECT_EN
    if (w_xfer && (w_addr != '0)) w_wr_nxt[w_addr] = 1'b1;
`else
    if (w_xfer) w_wr_nxt[w_addr] = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= S_UNLOCKED;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wr     <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_wr     <= w_wr_nxt;
      if (w_xfer) r_data <= w_data;
    end
  end

  // Gating with reset keeps an in-flight write out of the Registers.
  assign reg_write = reset ? '0 : r_wr;
  assign reg_input = r_data;
  assign locked    = (r_state == S_LOCKED);

endmodule
